// File: rtl/sig_capture_pkg.sv
// rtl/sig_capture_pkg.sv - shared state encoding and trigger polarity constants for sig_capture
// Contents: state_t (IDLE, ARMED, CAPTURE), TRIG_RISE / TRIG_FALL edge selectors.
package sig_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic TRIG_RISE = 1'b1;
  localparam logic TRIG_FALL = 1'b0;

endpackage

// File: rtl/sig_sync.sv
// rtl/sig_sync.sv - two-flop synchroniser plus delay flop with edge detect
// Ports: clk, rst (sync, active-high), sig (async raw input),
//        sig_s (synchronised level), rise / fall (single-cycle edge flags on sig_s).
module sig_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic sig_s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      dly  <= 1'b0;
    end else begin
      meta <= sig;
      sync <= meta;
      dly  <= sync;
    end
  end

  assign sig_s = sync;
  assign rise  = sync & ~dly;
  assign fall  = ~sync & dly;

endmodule

// File: rtl/sig_capture.sv
// rtl/sig_capture.sv - armed edge-triggered capture of a 1-bit signal, decimated and packed into bytes
// Ports: clk, rst (sync, active-high), sig (async raw input), arm (start pulse),
//        stb (one-cycle new-byte strobe), value (packed byte, bit 0 = oldest sample),
//        busy (high while ARMED or CAPTURE).
module sig_capture
  import sig_capture_pkg::*;
#(
  parameter int   DECIM     = 4,
  parameter int   NBYTES    = 512,
  parameter logic TRIG_EDGE = TRIG_RISE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic       arm,
  output logic       stb,
  output logic [7:0] value,
  output logic       busy
);

  localparam int DW = $clog2(DECIM);
  localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [DW-1:0] DEC_LAST  = DW'(DECIM - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

  state_t         state;
  state_t         state_nxt;
  logic           sig_s;
  logic           rise;
  logic           fall;
  logic           trig_edge;
  logic           trig;
  logic           sample;
  logic           byte_done;
  logic [DW-1:0]  dec_cnt;
  logic [2:0]     bit_cnt;
  logic [BW-1:0]  byte_cnt;
  logic [7:0]     shift;
  logic [7:0]     shift_nxt;

  sig_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .sig   (sig),
    .sig_s (sig_s),
    .rise  (rise),
    .fall  (fall)
  );

  assign trig_edge = (TRIG_EDGE == TRIG_RISE) ? rise : fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The trigger cycle itself is sample 0; afterwards a sample lands each
  // time the decimation counter reaches its last value.
  always_comb begin
    state_nxt = state;
    trig      = 1'b0;
    sample    = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (trig_edge) begin
          state_nxt = CAPTURE;
          trig      = 1'b1;
          sample    = 1'b1;
        end
      end
      CAPTURE: begin
        if (dec_cnt == DEC_LAST) begin
          sample = 1'b1;
          if ((bit_cnt == 3'd7) && (byte_cnt == BYTE_LAST)) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign byte_done = sample && (bit_cnt == 3'd7);
  assign shift_nxt = {sig_s, shift[7:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shift    <= '0;
      value    <= '0;
      stb      <= 1'b0;
    end else begin
      stb <= byte_done;
      if (trig) begin
        dec_cnt <= '0;
      end else if (state == CAPTURE) begin
        dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + DW'(1);
      end
      if (sample) begin
        shift   <= shift_nxt;
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) begin
          value    <= shift_nxt;
          byte_cnt <= (byte_cnt == BYTE_LAST) ? '0 : byte_cnt + BW'(1);
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sig_capture.sv
// tb/tb_sig_capture.sv - scoreboard bench for sig_capture, rising and falling trigger instances side by side
module tb_sig_capture;

  localparam int D  = 4;
  localparam int NB = 2;

  typedef struct {
    int         t;
    logic [7:0] v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sig = 1'b0;
  logic       arm = 1'b0;
  logic       stb_w   [2];
  logic [7:0] value_w [2];
  logic       busy_w  [2];

  int  cyc     = 0;
  int  checks  = 0;
  int  errors  = 0;
  bit  mon_en  = 1'b0;

  // index 1 = rising-edge instance, index 0 = falling-edge instance
  sig_capture #(.DECIM(D), .NBYTES(NB), .TRIG_EDGE(1'b1)) u_rise (
    .clk(clk), .rst(rst), .sig(sig), .arm(arm),
    .stb(stb_w[1]), .value(value_w[1]), .busy(busy_w[1])
  );

  sig_capture #(.DECIM(D), .NBYTES(NB), .TRIG_EDGE(1'b0)) u_fall (
    .clk(clk), .rst(rst), .sig(sig), .arm(arm),
    .stb(stb_w[0]), .value(value_w[0]), .busy(busy_w[0])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: abstract phases 0 idle, 1 armed, 2 capturing.
  bit         hist [int];
  int         last_rst = 0;
  int         ms    [2] = '{0, 0};
  int         t0    [2];
  int         nbits [2];
  int         nbyt  [2];
  logic [7:0] acc   [2];
  logic       m_busy  [2] = '{1'b0, 1'b0};
  logic [7:0] m_value [2] = '{8'h00, 8'h00};
  exp_t       q [2][$];

  // Synchronised level seen by the design in period c: the pin value two
  // periods earlier, or 0 while the synchroniser is still flushing a reset.
  function automatic bit ss(int c);
    if (c - 2 <= last_rst) return 1'b0;
    if (!hist.exists(c - 2)) return 1'b0;
    return hist[c - 2];
  endfunction

  always @(negedge clk) begin
    int   c;
    bit   s;
    bit   sp;
    bit   hit;
    exp_t ent;
    c = cyc;
    hist[c] = sig;
    if (rst) last_rst = c;
    for (int e = 0; e < 2; e++) begin
      if (rst) begin
        ms[e] = 0;
        while (q[e].size() > 0 && q[e][q[e].size()-1].t > c) void'(q[e].pop_back());
        m_busy[e]  <= 1'b0;
        m_value[e] <= 8'h00;
      end else begin
        s   = ss(c);
        sp  = ss(c - 1);
        hit = (e == 1) ? (s && !sp) : (!s && sp);
        if (ms[e] == 0) begin
          if (arm) ms[e] = 1;
        end else if (ms[e] == 1) begin
          if (hit) begin
            ms[e] = 2; t0[e] = c; nbits[e] = 0; nbyt[e] = 0; acc[e] = 8'h00;
          end
        end
        if (ms[e] == 2 && ((c - t0[e]) % D) == 0) begin
          acc[e][nbits[e]] = s;
          nbits[e]++;
          if (nbits[e] == 8) begin
            ent.t = c + 1;
            ent.v = acc[e];
            q[e].push_back(ent);
            m_value[e] <= acc[e];
            nbits[e] = 0;
            nbyt[e]++;
            if (nbyt[e] == NB) ms[e] = 0;
          end
        end
        m_busy[e] <= (ms[e] != 0);
      end
    end
  end

  // Monitor: strobe timing and byte from the scoreboard, level outputs from the model.
  always @(negedge clk) begin
    logic       exp_stb;
    logic [7:0] exp_v;
    if (mon_en) begin
      for (int e = 0; e < 2; e++) begin
        exp_stb = 1'b0;
        exp_v   = m_value[e];
        if (q[e].size() > 0 && q[e][0].t == cyc) begin
          exp_stb = 1'b1;
          exp_v   = q[e][0].v;
          void'(q[e].pop_front());
        end
        checks++;
        if (stb_w[e] !== exp_stb) begin
          errors++;
          $display("FAIL stb[%0d] cyc %0d: got %b want %b", e, cyc, stb_w[e], exp_stb);
        end
        checks++;
        if (value_w[e] !== exp_v) begin
          errors++;
          $display("FAIL value[%0d] cyc %0d: got %02h want %02h", e, cyc, value_w[e], exp_v);
        end
        checks++;
        if (busy_w[e] !== m_busy[e]) begin
          errors++;
          $display("FAIL busy[%0d] cyc %0d: got %b want %b", e, cyc, busy_w[e], m_busy[e]);
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    #1;
    tick(3);
    rst    = 1'b0;
    mon_en = 1'b1;

    // idle with a busy pin and no arm
    for (int i = 0; i < 200; i++) begin
      sig = 1'($urandom_range(0, 1));
      tick(1);
    end

    // constant high for the rising instance, then constant low for the falling one
    sig = 1'b0;
    tick(10);
    pulse_arm();
    tick(5);
    sig = 1'b1;
    tick(80);
    sig = 1'b0;
    tick(80);

    // alternating level aligned to the 4-cycle sample grid
    pulse_arm();
    tick(6);
    for (int i = 0; i < 20; i++) begin
      sig = ~sig;
      tick(4);
    end
    sig = 1'b0;
    tick(80);

    // edge coinciding with arm must not trigger
    sig = 1'b1;
    tick(2);
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(30);
    sig = 1'b0;
    tick(4);
    sig = 1'b1;
    tick(80);

    // abort three samples into byte 0, then a clean re-run
    sig = 1'b0;
    tick(80);
    pulse_arm();
    tick(5);
    sig = 1'b1;
    tick(11);
    pulse_rst();
    tick(5);
    sig = 1'b0;
    pulse_arm();
    tick(6);
    sig = 1'b1;
    tick(80);

    // arm held high across captures: re-arm in the final-strobe cycle
    arm = 1'b1;
    for (int i = 0; i < 60; i++) begin
      sig = 1'($urandom_range(0, 1));
      tick($urandom_range(1, 6));
    end
    arm = 1'b0;

    // randomized mix of arms, levels and occasional resets
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) arm = 1'b1;
      if ($urandom_range(0, 60) == 0) rst = 1'b1;
      sig = 1'($urandom_range(0, 1));
      tick(1);
      arm = 1'b0;
      rst = 1'b0;
      tick($urandom_range(0, 8));
    end

    // drain with a bounded wait
    for (int i = 0; i < 200 && (q[0].size() + q[1].size()) > 0; i++) tick(1);
    tick(3);
    for (int e = 0; e < 2; e++) begin
      checks++;
      if (q[e].size() != 0) begin
        errors++;
        $display("FAIL drain[%0d]: got %0d pending strobes want 0", e, q[e].size());
      end
    end
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
